// File: rtl/pipeline_stage_register_pkg.sv
// Shared types and widths for the MIPS inter-stage pipeline registers.
// Imported by the stage register, its interface and the bench.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int CTRL_W_DEFAULT = 24;
  localparam int DATA_W_DEFAULT = 128;

  // Control bundle widths per pipeline boundary.
  localparam int FD_CTRL_W = 4;
  localparam int DE_CTRL_W = 24;
  localparam int EM_CTRL_W = 8;
  localparam int MW_CTRL_W = 4;

endpackage

// File: rtl/pipeline_stage_register_if.sv
// Upstream and downstream handshake bundle of one pipeline stage register.
// Same interface as seen by the producer/consumer side (master) and the register (slave).
interface pipeline_stage_register_if
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  // Handshake: a beat moves on a rising clk edge where valid && ready are both 1.
  // valid must not depend on ready; ctrl/data are only meaningful while valid is 1.
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipeline_stage_register_sat_counter.sv
// Saturating event counter used for the optional stage statistics.
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Two-entry skid-buffer pipeline register with stall and synchronous flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cycles / flush_drops counters.
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int CLEAR_DATA = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  pipeline_stage_register_if.slave   bus,
  output stage_state_e               state
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]                stall_cycles,
  output logic [15:0]                flush_drops
`endif
);

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_ready_q;
  logic              in_xfer, out_xfer, out_valid;

  assign out_valid = (state != EMPTY);
  assign in_xfer   = bus.in_valid && in_ready_q;
  assign out_xfer  = out_valid && bus.out_ready;

  // Outputs come straight from the main-entry flops; main_ctrl is cleared
  // whenever the stage empties so a bubble always carries a NOP.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = main_ctrl;
  assign bus.out_data  = main_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      main_ctrl  <= '0;
      in_ready_q <= 1'b1;
      if (CLEAR_DATA != 0) main_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_ctrl <= bus.in_ctrl;
            main_data <= bus.in_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl <= bus.in_ctrl;
            main_data <= bus.in_data;
          end else if (in_xfer) begin
            skid_ctrl  <= bus.in_ctrl;
            skid_data  <= bus.in_data;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            if (CLEAR_DATA != 0) main_data <= '0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_xfer) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          main_ctrl  <= '0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc, flush_inc;

  assign stall_inc = out_valid && !bus.out_ready;
  // A flush only loses work if something held is not leaving this cycle.
  assign flush_inc = flush && ((state == TWO) || ((state == ONE) && !out_xfer));

  pipe_sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  pipe_sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_drops)
  );
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Scoreboard bench for pipeline_stage_register: directed vectors plus a short random run.
module tb_pipeline_stage_register;
  import pipeline_pkg::*;

  localparam int CW = 24;
  localparam int DW = 128;

  logic clk;
  logic reset;
  logic flush;
  stage_state_e state;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_drops;
`endif

  pipeline_stage_register_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipeline_stage_register #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .state        (state)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_drops  (flush_drops)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [CW+DW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    mk_data = {4{8'hD0, c}};
  endfunction

  // Monitor: every beat leaving the DUT must match the head of the queue,
  // and a bubble must present zero control and zero data.
  always @(negedge clk) begin
    logic [CW+DW-1:0] e;
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus.out_ctrl, '1);
        end else begin
          e = exp_q.pop_front();
          chk("out_ctrl", bus.out_ctrl, e[CW+DW-1:DW]);
          chk("out_data", bus.out_data, e[DW-1:0]);
        end
      end
      if (!bus.out_valid) begin
        chk("bubble_ctrl", bus.out_ctrl, '0);
        chk("bubble_data", bus.out_data, '0);
      end
    end
  end

  // Expected-queue update for the coming edge: flush drops everything held
  // (after the monitor has taken any beat leaving on that same edge).
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_ctrl, bus.in_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = mk_data(c);
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_ctrl", bus.out_ctrl, '0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_state", state, EMPTY);
    exp_q.delete();
    #1 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("init_out_valid", bus.out_valid, 1'b0);
    chk("init_in_ready", bus.in_ready, 1'b1);

    // Streaming: each ctrl value appears one cycle after it is offered.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CW'(k), 1'b1, 1'b0);
      tick();
      chk("stream_ctrl", bus.out_ctrl, DW'(k));
      chk("stream_in_ready", bus.in_ready, 1'b1);
      chk("stream_state", state, ONE);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("stream_drained", bus.out_valid, 1'b0);

    // Stall: fill both entries, then release.
    drive(1'b1, 24'hA5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("stall_state", state, TWO);
    chk("stall_in_ready", bus.in_ready, 1'b0);
    chk("stall_ctrl", bus.out_ctrl, 24'hA5);
    tick();
    chk("stall_hold_ctrl", bus.out_ctrl, 24'hA5);
    chk("stall_hold_state", state, TWO);
    bus.out_ready = 1'b1;
    tick();
    chk("release_ctrl", bus.out_ctrl, 24'h5A);
    chk("release_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("release_empty", bus.out_valid, 1'b0);

    // Flush with a concurrent input beat: 0x3C must never emerge.
    drive(1'b1, 24'h11, 1'b0, 1'b0);
    tick();
    chk("pre_flush_state", state, ONE);
    drive(1'b1, 24'h3C, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ctrl", bus.out_ctrl, '0);
    chk("flush_data", bus.out_data, '0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Flush while the head beat leaves: the head still completes, the skid is dropped.
    drive(1'b1, 24'h41, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'h42, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("flush_out_state", state, EMPTY);
    repeat (2) tick();

    // Reset mid-stream with both entries held.
    drive(1'b1, 24'h77, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'h78, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_state", state, TWO);
    pulse_reset();
    bus.out_ready = 1'b1;
    repeat (2) tick();

`ifdef PIPE_STAGE_STATS_EN
    pulse_reset();
    drive(1'b1, 24'h21, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("stall_cycles_5", stall_cycles, 16'd5);
    drive(1'b1, 24'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_drops_1", flush_drops, 16'd1);
    chk("stall_cycles_7", stall_cycles, 16'd7);
    pulse_reset();
    drive(1'b1, 24'h23, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (70000) tick();
    chk("stall_saturate", stall_cycles, 16'hFFFF);
    chk("flush_drops_after_rst", flush_drops, 16'd0);
    pulse_reset();
    bus.out_ready = 1'b1;
    tick();
`endif

    // Random valid/ready/flush traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom_range(1, 24'hFFFFFF)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("queue_empty", DW'(exp_q.size()), '0);
    chk("final_state", state, EMPTY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
